// File: rtl/ptat_pkg.sv
// Shared types and widths for the PTAT averaging controller.
package ptat_pkg;
    localparam int A2D_W = 12;

    typedef enum logic [1:0] {IDLE, WAIT, CONV, DONE} ptat_state_t;
endpackage

// File: rtl/ptat_period_tmr.sv
// Clear/enable up-counter with a terminal-count flag at LIMIT-1.
// Used both as the sample-period timer and as the conversion watchdog.
module ptat_period_tmr #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = en && (cnt == LAST);
endmodule

// File: rtl/ptat_avg_ctrl.sv
// PTAT A2D sequencer: periodic strt, accumulate 2^AVG_LOG2 results, publish rounded average.
// Define PTAT_TIMEOUT_EN to add the CONV watchdog and sticky err flag.
module ptat_avg_ctrl
    import ptat_pkg::*;
#(
    parameter int PERIOD   = 1024,
    parameter int AVG_LOG2 = 3,
    parameter int TIMEOUT  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             strt,
    input  logic             cmplt,
    input  logic [A2D_W-1:0] a2d,
    output logic [A2D_W-1:0] temp,
    output logic             temp_vld,
    output logic             busy,
    output logic             err
);
    localparam int ACC_W = A2D_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_SMP = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [ACC_W-1:0] RND      = ACC_W'((1 << AVG_LOG2) >> 1);

    ptat_state_t      state, state_next;
    logic [ACC_W-1:0] accum, acc_sum, rnd_sum;
    logic [CNT_W-1:0] smp_cnt;
    logic [A2D_W-1:0] temp_next;
    logic             strt_next, acc_add, acc_clr, publish, last_smp;
    logic             period_clr, period_en, period_tc;

    assign period_clr = (state != WAIT);
    assign period_en  = (state == WAIT);

    ptat_period_tmr #(.LIMIT(PERIOD)) u_period (
        .clk (clk),
        .rst (rst),
        .clr (period_clr),
        .en  (period_en),
        .tc  (period_tc)
    );

`ifdef PTAT_TIMEOUT_EN
    logic wd_clr, wd_en, wd_tc, err_set;

    assign wd_clr = (state != CONV);
    assign wd_en  = (state == CONV);

    ptat_period_tmr #(.LIMIT(TIMEOUT)) u_watchdog (
        .clk (clk),
        .rst (rst),
        .clr (wd_clr),
        .en  (wd_en),
        .tc  (wd_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign err = 1'b0;
`endif

    // Sum of 2^AVG_LOG2 12-bit samples plus half an LSB cannot overflow ACC_W bits
    assign acc_sum   = accum + ACC_W'(a2d);
    assign rnd_sum   = acc_sum + RND;
    assign temp_next = A2D_W'(rnd_sum >> AVG_LOG2);
    assign last_smp  = (smp_cnt == LAST_SMP);

    always_comb begin
        state_next = state;
        strt_next  = 1'b0;
        acc_add    = 1'b0;
        publish    = 1'b0;
`ifdef PTAT_TIMEOUT_EN
        err_set    = 1'b0;
`endif
        case (state)
            IDLE: if (en) state_next = WAIT;
            WAIT: begin
                if (!en) begin
                    state_next = IDLE;
                end else if (period_tc) begin
                    state_next = CONV;
                    strt_next  = 1'b1;
                end
            end
            // en is deliberately ignored until the in-flight conversion completes
            CONV: begin
                if (cmplt) begin
                    acc_add = 1'b1;
                    if (last_smp) begin
                        publish    = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = en ? WAIT : IDLE;
                    end
                end
`ifdef PTAT_TIMEOUT_EN
                else if (wd_tc) begin
                    err_set    = 1'b1;
                    state_next = en ? WAIT : IDLE;
                end
`endif
            end
            DONE:    state_next = en ? WAIT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign acc_clr = (state_next == IDLE) || (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            accum    <= '0;
            smp_cnt  <= '0;
            temp     <= '0;
            temp_vld <= 1'b0;
            strt     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            strt     <= strt_next;
            temp_vld <= publish;
            busy     <= (state_next != IDLE);
            if (publish) temp <= temp_next;
            if (acc_clr) begin
                accum   <= '0;
                smp_cnt <= '0;
            end else if (acc_add) begin
                accum   <= acc_sum;
                smp_cnt <= smp_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ptat_avg_ctrl.sv
// Scoreboard bench for ptat_avg_ctrl with PERIOD=16, AVG_LOG2=3, TIMEOUT=32.
// Build with +define+PTAT_TIMEOUT_EN to also exercise the watchdog.
module tb_ptat_avg_ctrl;
    localparam int PERIOD   = 16;
    localparam int AVG_LOG2 = 3;
    localparam int TIMEOUT  = 32;

    logic        clk = 1'b0;
    logic        rst, en, cmplt;
    logic [11:0] a2d;
    logic        strt, temp_vld, busy, err;
    logic [11:0] temp;

    int          checks = 0;
    int          passes = 0;
    logic [11:0] exp_q[$];
    logic [11:0] vec[8];
    int          n;
    int          strt_hits;

    always #5 clk = ~clk;

    ptat_avg_ctrl #(
        .PERIOD   (PERIOD),
        .AVG_LOG2 (AVG_LOG2),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .strt     (strt),
        .cmplt    (cmplt),
        .a2d      (a2d),
        .temp     (temp),
        .temp_vld (temp_vld),
        .busy     (busy),
        .err      (err)
    );

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    // Monitor: every temp_vld must match the oldest expected average
    always @(negedge clk) begin
        if (temp_vld) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_vld: got temp %0h, expected no temp_vld", temp);
            end else begin
                check_output("temp", int'(temp), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic wait_strt(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (strt) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic give_cmplt(input logic [11:0] v, input int gap);
        repeat (gap) @(negedge clk);
        cmplt = 1'b1;
        a2d   = v;
        @(negedge clk);
        cmplt = 1'b0;
        a2d   = 12'h5A5;
    endtask

    task automatic apply_stimulus(input logic [11:0] v);
        int c;
        wait_strt(c);
        check_output("strt_seen", int'(c > 0), 1);
        if (c > 0) give_cmplt(v, 2);
    endtask

    task automatic run_group(input logic [11:0] s[8], input logic [11:0] expv, input int first);
        for (int i = first; i < 8; i++) begin
            if (i == 7) exp_q.push_back(expv);
            apply_stimulus(s[i]);
        end
        check_output("vld_latency", int'(temp_vld), 1);
        @(negedge clk);
        check_output("vld_pulse", int'(temp_vld), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "[TB] simulation hung");
    end

    initial begin
        rst = 1'b1; en = 1'b0; cmplt = 1'b0; a2d = 12'h000;
        repeat (3) @(negedge clk);
        check_output("rst_temp", int'(temp), 0);
        check_output("rst_vld", int'(temp_vld), 0);
        check_output("rst_strt", int'(strt), 0);
        check_output("rst_busy", int'(busy), 0);
        check_output("rst_err", int'(err), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // First strt arrives after the IDLE cycle plus PERIOD WAIT cycles
        $display("[TB] strt timing and first average");
        en = 1'b1;
        wait_strt(n);
        check_output("strt_latency", n, 17);
        check_output("busy_conv", int'(busy), 1);
        strt_hits = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (strt) strt_hits++;
        end
        check_output("strt_single", strt_hits, 0);
        for (int i = 0; i < 8; i++) vec[i] = 12'hABC;
        exp_q.push_back(12'hABC);
        exp_q.pop_back();
        give_cmplt(12'hABC, 0);
        run_group(vec, 12'hABC, 1);

        $display("[TB] mixed samples");
        vec = '{12'hABC, 12'h89A, 12'hABC, 12'hFFE, 12'h00C, 12'h012, 12'hFF0, 12'h789};
        run_group(vec, 12'h8B5, 0);

        $display("[TB] rounding and full scale");
        vec = '{12'h004, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000};
        run_group(vec, 12'h001, 0);
        repeat (5) @(negedge clk);
        check_output("temp_hold", int'(temp), 12'h001);
        for (int i = 0; i < 8; i++) vec[i] = 12'hFFF;
        run_group(vec, 12'hFFF, 0);

        // en dropped while a conversion is in flight: it completes, then the partial sum is dropped
        $display("[TB] en dropped mid-average");
        for (int i = 0; i < 3; i++) apply_stimulus(12'h100);
        wait_strt(n);
        check_output("strt_seen_4th", int'(n > 0), 1);
        en = 1'b0;
        give_cmplt(12'h100, 2);
        check_output("idle_busy", int'(busy), 0);
        strt_hits = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (strt) strt_hits++;
        end
        check_output("idle_no_strt", strt_hits, 0);
        check_output("idle_temp_hold", int'(temp), 12'hFFF);
        en = 1'b1;
        vec = '{12'h010, 12'h020, 12'h030, 12'h040, 12'h050, 12'h060, 12'h070, 12'h080};
        run_group(vec, 12'h048, 0);

        $display("[TB] reset mid-conversion");
        apply_stimulus(12'h333);
        wait_strt(n);
        check_output("strt_seen_rst", int'(n > 0), 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_output("rst2_temp", int'(temp), 0);
        check_output("rst2_vld", int'(temp_vld), 0);
        check_output("rst2_strt", int'(strt), 0);
        check_output("rst2_busy", int'(busy), 0);
        check_output("rst2_err", int'(err), 0);
        give_cmplt(12'hFFF, 2);
        for (int i = 0; i < 8; i++) vec[i] = 12'h200;
        run_group(vec, 12'h200, 0);

`ifdef PTAT_TIMEOUT_EN
        $display("[TB] conversion watchdog");
        wait_strt(n);
        check_output("strt_seen_wd", int'(n > 0), 1);
        n = -1;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (err) begin
                n = i;
                break;
            end
        end
        check_output("err_latency", n, 32);
        wait_strt(n);
        check_output("strt_reissue", n, 16);
        give_cmplt(12'h123, 2);
        repeat (5) @(negedge clk);
        check_output("err_sticky", int'(err), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("err_cleared", int'(err), 0);
`else
        check_output("err_tied", int'(err), 0);
`endif

        en = 1'b0;
        repeat (4) @(negedge clk);
        check_output("sb_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
